// File: rtl/jedro_1_ifu_prefetch.sv
// -----------------------------------------------------------------------------
// jedro_1_ifu_prefetch
//   Instruction fetch unit with a small prefetch FIFO. Issues sequential,
//   word-aligned fetches to a registered (1-cycle latency) instruction ROM and
//   buffers the returned words together with their PC for the decoder. A
//   redirect from execute flushes buffered and in-flight words and restarts
//   fetching at the (word-aligned) target.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active high
//   rom_req_o      ROM read request this cycle
//   rom_addr_o     ROM byte address (word aligned)
//   rom_rdata_i    ROM read data, valid the cycle after a request
//   jmp_i          redirect request (highest priority)
//   jmp_addr_i     redirect target
//   instr_valid_o  FIFO head holds a valid instruction
//   instr_ready_i  decoder accepts the head this cycle
//   instr_o        head instruction
//   pc_o           PC of head instruction
//   count_o        number of buffered entries
// -----------------------------------------------------------------------------
module jedro_1_ifu_prefetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          rom_req_o,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_rdata_i,
    input  logic                          jmp_i,
    input  logic [ADDR_WIDTH-1:0]         jmp_addr_i,
    output logic                          instr_valid_o,
    input  logic                          instr_ready_i,
    output logic [DATA_WIDTH-1:0]         instr_o,
    output logic [ADDR_WIDTH-1:0]         pc_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W:0]        DEPTH_OCC = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_INC    = ADDR_WIDTH'(4);

    // Buffer storage; contents need no reset because the pointers and the
    // count define what is valid.
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];

    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q,  pend_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  drop_q,     drop_d;

    logic                  pop;
    logic                  push;
    logic                  req;
    logic [CNT_W:0]        occupancy;

    // Only the word-address bits of a redirect target are meaningful.
    logic unused_jmp_lsb;
    assign unused_jmp_lsb = ^jmp_addr_i[1:0];

    assign instr_valid_o = !rst_i && (count_q != '0);
    assign pop           = instr_valid_o && instr_ready_i;

    // A response is accepted unless a redirect is happening now or the
    // request that produced it was marked stale.
    assign push = inflight_q && !drop_q && !jmp_i;

    // Reserve a slot for every outstanding request so a response can never
    // land in a full buffer.
    assign occupancy = {1'b0, count_q}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};
    assign req       = !rst_i && !jmp_i && (occupancy < DEPTH_OCC);

    assign rom_req_o  = req;
    assign rom_addr_o = {fetch_pc_q[ADDR_WIDTH-1:2], 2'b00};
    assign count_o    = rst_i ? '0 : count_q;
    assign instr_o    = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
    assign pc_o       = instr_valid_o ? pc_mem_q[rd_ptr_q]   : '0;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        inflight_d = 1'b0;
        drop_d     = 1'b0;

        if (jmp_i) begin
            // Flush everything; the response arriving this cycle is lost and
            // no new request is issued until next cycle.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
            drop_d     = 1'b1;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (req) begin
                pend_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_INC;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= BOOT_ADDR;
            pend_pc_q  <= BOOT_ADDR;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            data_mem_q[wr_ptr_q] <= rom_rdata_i;
            pc_mem_q[wr_ptr_q]   <= pend_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (count_q == DEPTH_CNT)));

endmodule

// File: tb/tb_jedro_1_ifu_prefetch.sv
module tb_jedro_1_ifu_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jmp = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] jmp_addr = '0;
    logic [31:0] rom_rdata = '0;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    jedro_1_ifu_prefetch #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH), .BOOT_ADDR(32'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
        .jmp_i(jmp), .jmp_addr_i(jmp_addr),
        .instr_valid_o(instr_valid), .instr_ready_i(ready),
        .instr_o(instr), .pc_o(pc), .count_o(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Registered ROM; unrequested cycles return garbage that must never be buffered.
    always @(posedge clk) rom_rdata <= rom_req ? rom_word(rom_addr) : $urandom();

    // Reference model: queue of PCs of words the decoder should see, in order.
    logic [31:0] mq[$];
    bit          m_infl = 1'b0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_fetch = '0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [2:0]  s_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One clock cycle: drive inputs, check outputs at negedge against the
    // model, then advance the model at the rising edge.
    task automatic step(input logic r, input logic j, input logic [31:0] ja, input logic rd);
        bit e_valid, e_pop, e_req;
        rst = r; jmp = j; jmp_addr = ja; ready = rd;
        @(negedge clk);
        s_req = rom_req; s_addr = rom_addr; s_valid = instr_valid;
        s_pc = pc; s_instr = instr; s_count = count;
        e_valid = !r && (mq.size() != 0);
        e_pop   = e_valid && rd;
        e_req   = !r && !j && ((mq.size() + int'(m_infl) - int'(e_pop)) < DEPTH);
        chk("m_valid", 32'(s_valid), 32'(e_valid));
        chk("m_count", 32'(s_count), r ? 32'd0 : 32'(mq.size()));
        chk("m_req",   32'(s_req),   32'(e_req));
        chk("m_addr",  s_addr,       m_fetch);
        if (e_valid) begin
            chk("m_pc",    s_pc,    mq[0]);
            chk("m_instr", s_instr, rom_word(mq[0]));
        end else begin
            chk("m_pc0",    s_pc,    32'h0);
            chk("m_instr0", s_instr, 32'h0);
        end
        @(posedge clk);
        if (r) begin
            mq.delete(); m_infl = 1'b0; m_fetch = 32'h0;
        end else if (j) begin
            mq.delete(); m_infl = 1'b0; m_fetch = {ja[31:2], 2'b00};
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_pend);
            if (e_req) begin
                m_pend = m_fetch; m_fetch = m_fetch + 32'd4; m_infl = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
        #1;
    endtask

    typedef struct {
        logic        rst, jmp;
        logic [31:0] ja;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tv[14];

    initial begin
        logic [31:0] last_pc;
        bit found;
        // rst jmp ja rdy | req addr valid pc cnt
        tv[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0};
        tv[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
        tv[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0};
        tv[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1};
        tv[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1};
        tv[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 3'd1};
        tv[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h14, 1'b1, 32'h08, 3'd2};
        tv[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h18, 1'b1, 32'h08, 3'd3};
        tv[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h18, 1'b1, 32'h08, 3'd4};
        tv[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h18, 1'b1, 32'h08, 3'd4};
        tv[10] = '{1'b0, 1'b1, 32'h43, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C, 3'd3};
        tv[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0, 32'h00, 3'd0};
        tv[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 1'b0, 32'h00, 3'd0};
        tv[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h48, 1'b1, 32'h40, 3'd1};

        @(posedge clk); #1;

        // Fill, back-pressure to full, redirect to unaligned 0x43 with 3 entries + in-flight.
        for (int i = 0; i < 14; i++) begin
            step(tv[i].rst, tv[i].jmp, tv[i].ja, tv[i].rdy);
            chk($sformatf("tv%0d_req", i),   32'(s_req),   32'(tv[i].e_req));
            chk($sformatf("tv%0d_addr", i),  s_addr,       tv[i].e_addr);
            chk($sformatf("tv%0d_valid", i), 32'(s_valid), 32'(tv[i].e_valid));
            chk($sformatf("tv%0d_pc", i),    s_pc,         tv[i].e_pc);
            chk($sformatf("tv%0d_count", i), 32'(s_count), 32'(tv[i].e_cnt));
            if (tv[i].e_valid) chk($sformatf("tv%0d_instr", i), s_instr, rom_word(tv[i].e_pc));
        end

        // Ready low for 10 cycles: saturate at DEPTH, requests stop.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_count", 32'(s_count), 32'(DEPTH));
        chk("stall_req",   32'(s_req),   32'd0);
        // Release: deliveries strictly consecutive.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        last_pc = s_pc;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk("release_valid", 32'(s_valid), 32'd1);
            chk("release_seq",   s_pc,         last_pc + 32'd4);
            last_pc = s_pc;
        end

        // Back-to-back redirects: last target wins, valid 3 cycles later.
        step(1'b0, 1'b1, 32'h100, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        found = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_valid) begin
                found = 1'b1;
                chk("b2b_first_pc", s_pc,   32'h200);
                chk("b2b_latency",  32'(k), 32'd3);
            end
        end
        if (!found) chk("b2b_timeout", 32'd0, 32'd1);

        // Fill to full, pop one (issues a request), reset while it is in flight.
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (s_count == 3'(DEPTH)) found = 1'b1;
        end
        chk("full_before_reset", 32'(found), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("pop_reissues_req", 32'(s_req), 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_rst_valid", 32'(s_valid), 32'd0);
        chk("post_rst_count", 32'(s_count), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_valid) begin
                found = 1'b1;
                chk("post_rst_first_pc", s_pc, 32'h0);
            end
        end
        if (!found) chk("post_rst_timeout", 32'd0, 32'd1);

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, j, rd;
            r  = ($urandom_range(0, 199) == 0);
            j  = !r && ($urandom_range(0, 29) == 0);
            rd = ($urandom_range(0, 9) < 7);
            step(r, j, $urandom(), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jedro_1_ifu_prefetch.md
Name: jedro_1_ifu_prefetch

Overview:
Instruction fetch unit with a small prefetch FIFO. It sits between the instruction ROM (registered, 1-cycle read latency) and the jedro_1 decoder. It generates sequential fetch addresses and buffers returned words together with their PC. On a jump/branch redirect from execute it flushes all buffered and in-flight words.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, fetch address width
FIFO_DEPTH, 4, prefetch buffer entries (power of 2, >=2)
BOOT_ADDR, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
rom_req_o  out  1  read request to instruction ROM this cycle
rom_addr_o  out  ADDR_WIDTH  ROM byte address (word aligned)
rom_rdata_i  in  DATA_WIDTH  ROM data; valid the cycle after a request
jmp_i  in  1  redirect request from execute
jmp_addr_i  in  ADDR_WIDTH  redirect target
instr_valid_o  out  1  FIFO head holds a valid instruction
instr_ready_i  in  1  decoder accepts head this cycle
instr_o  out  DATA_WIDTH  head instruction
pc_o  out  ADDR_WIDTH  PC of head instruction
count_o  out  $clog2(FIFO_DEPTH)+1  entries currently buffered

Behaviour:
- Reset (rst_i=1 at an edge): fetch_pc<=BOOT_ADDR; FIFO empty; in-flight flag 0; drop flag 0. Outputs during/after reset: rom_req_o=0, instr_valid_o=0, count_o=0, instr_o and pc_o=0. Reset mid-operation discards all buffered and in-flight words; any ROM data returned the cycle after reset is ignored.
- rom_addr_o = fetch_pc (registered) at all times, bits [1:0] always 0.
- Request rule: rom_req_o=1 when !rst_i && !jmp_i && (count + inflight - pop) < FIFO_DEPTH, where pop = instr_valid_o && instr_ready_i. On a request edge: fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), inflight<=1, and the request's address is stored as the pending PC.
- Response: in the cycle after a request, rom_rdata_i is pushed with the pending PC unless the drop flag is set. Push and pop in the same cycle are legal. The reservation rule guarantees no push into a full FIFO. Overflow must be asserted against in simulation.
- Latency: request in cycle N; data on rom_rdata_i in N+1; instr_valid_o in N+2.
- Throughput: with instr_ready_i held 1, one instruction per cycle sustained after the 2-cycle fill.
- Redirect (jmp_i=1): highest priority over pop and push.
  - At the edge: FIFO cleared (count 0); fetch_pc <= {jmp_addr_i[ADDR_WIDTH-1:2],2'b00}.
  - If a request was issued the previous cycle, its response (arriving in the jmp_i cycle) is not pushed.
  - rom_req_o=0 during the jmp_i cycle. The first target request is issued the next cycle, so the target instruction is valid 3 cycles after jmp_i.
  - Back-to-back jmp_i: the last target wins.
- instr_o/pc_o are stable while instr_valid_o=1 and instr_ready_i=0. FIFO uses circular read/write pointers wrapping at FIFO_DEPTH.

Test Plan:
- Reset release, ROM words 0x00000013 at 0x0, 0x00100093 at 0x4, instr_ready_i=1 → instr_valid_o rises 2 cycles after reset drop; pc_o sequence 0x0,0x4,0x8… one per cycle; instr_o matches ROM.
- instr_ready_i=0 for 10 cycles → count_o saturates at 4; rom_req_o drops; no overflow; releasing ready delivers PCs 0x0..0xC in order with no gap or duplicate.
- jmp_i with jmp_addr_i=0x40 while FIFO holds 3 entries and a request is in flight → count_o=0 next cycle; rom_req_o=0 in the jmp cycle; next delivered pc_o=0x40 exactly 3 cycles later; no stale PC appears.
- jmp_addr_i=0x43 → fetch restarts at 0x40.
- jmp_i on two consecutive cycles (0x100 then 0x200) → first delivered PC is 0x200.
- rst_i asserted for 1 cycle mid-stream with FIFO full → instr_valid_o=0, count_o=0 next cycle; restart at BOOT_ADDR; the in-flight word is never delivered.
